// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, per-layer feature-map dimensions and writer state encoding
package cnn_pkg;
  localparam int DATA_W = 16;
  localparam int ACC_W = 32;
  localparam int C1_OUT_W = 24;
  localparam int C1_OUT_H = 24;
  localparam int P1_OUT_W = 12;
  localparam int P1_OUT_H = 12;
  localparam int C2_OUT_W = 8;
  localparam int C2_OUT_H = 8;
  localparam int P2_OUT_W = 4;
  localparam int P2_OUT_H = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} wr_state_t;
endpackage

// File: rtl/quant_sat.sv
// quant_sat: arithmetic shift, optional ReLU and saturation of an accumulator to a stored word
module quant_sat #(
  parameter int ACC_W = 32,
  parameter int DATA_W = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int RELU = 1
) (
  input  logic signed [ACC_W-1:0]  d,
  output logic signed [DATA_W-1:0] q
);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] s, r;
  always_comb begin
    s = d >>> FRAC_SHIFT;
    r = (RELU != 0 && s < 0) ? '0 : s;
    q = r > MAXV ? MAXV[DATA_W-1:0] : r < MINV ? MINV[DATA_W-1:0] : r[DATA_W-1:0];
  end
endmodule

// File: rtl/layer_out_writer.sv
// layer_out_writer: quantizes a raster pixel stream and writes pixel pairs through both RAM ports
module layer_out_writer import cnn_pkg::*; #(
  parameter int OUT_W = 24,
  parameter int OUT_H = 24,
  parameter int ACC_W = 32,
  parameter int DATA_W = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int RELU = 1,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] wdata2,
  output logic              we1,
  output logic              we2,
  output logic              done
);
  localparam int TOTAL = OUT_W * OUT_H;
  localparam int CW = $clog2(TOTAL + 1);
  wr_state_t state, nstate;
  logic [CW-1:0] n;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] hold, q;
  logic hold_v, accept, last;
  quant_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC_SHIFT(FRAC_SHIFT), .RELU(RELU)) u_q (
    .d(in_data),
    .q(q)
  );
  always_comb begin
    in_ready = state == RUN && n < CW'(TOTAL);
    accept = in_valid && in_ready;
    last = n == CW'(TOTAL - 1);
    done = state == DONE;
    nstate = (state != RUN && start) ? RUN : (state == RUN && n == CW'(TOTAL) && we1) ? DONE : state;
  end
  // an odd final pixel is written alone instead of waiting in hold for a partner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      n <= '0;
      base <= '0;
      hold <= '0;
      hold_v <= 1'b0;
      addr1 <= '0;
      addr2 <= '0;
      wdata1 <= '0;
      wdata2 <= '0;
      we1 <= 1'b0;
      we2 <= 1'b0;
    end else begin
      state <= nstate;
      we1 <= 1'b0;
      we2 <= 1'b0;
      if (state != RUN && start) begin
        n <= '0;
        base <= '0;
        hold_v <= 1'b0;
      end else if (accept) begin
        n <= n + CW'(1);
        if (hold_v) begin
          we1 <= 1'b1;
          we2 <= 1'b1;
          addr1 <= base;
          addr2 <= base + ADDR_W'(1);
          wdata1 <= hold;
          wdata2 <= q;
          hold_v <= 1'b0;
          if (!last) base <= base + ADDR_W'(2);
        end else if (last) begin
          we1 <= 1'b1;
          addr1 <= base;
          wdata1 <= q;
        end else begin
          hold <= q;
          hold_v <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_layer_out_writer.sv
// tb_layer_out_writer: directed scoreboard bench for a 3x3 ReLU writer and a 24x24 signed writer
module tb_layer_out_writer;
  typedef struct packed {
    logic w2;
    logic [9:0] a1;
    logic [9:0] a2;
    logic [15:0] d1;
    logic [15:0] d2;
  } wr_t;
  logic clk = 0, rst_n = 0;
  logic start_a = 0, vld_a = 0, start_b = 0, vld_b = 0;
  logic [31:0] din_a = 0, din_b = 0;
  logic rdy_a, we1_a, we2_a, done_a, rdy_b, we1_b, we2_b, done_b;
  logic [9:0] a1_a, a2_a, a1_b, a2_b;
  logic [15:0] d1_a, d2_a, d1_b, d2_b;
  int n_checks = 0, n_err = 0;
  int tot[2] = '{9, 576};
  int n_m[2], base_m[2], hv_m[2];
  logic [15:0] hold_m[2];
  wr_t qa[$], qb[$];
  always #5 clk = ~clk;
  layer_out_writer #(.OUT_W(3), .OUT_H(3), .ACC_W(32), .DATA_W(16), .FRAC_SHIFT(8), .RELU(1), .ADDR_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(vld_a), .in_data(din_a), .in_ready(rdy_a),
    .addr1(a1_a), .addr2(a2_a), .wdata1(d1_a), .wdata2(d2_a), .we1(we1_a), .we2(we2_a), .done(done_a)
  );
  layer_out_writer #(.OUT_W(24), .OUT_H(24), .ACC_W(32), .DATA_W(16), .FRAC_SHIFT(8), .RELU(0), .ADDR_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(vld_b), .in_data(din_b), .in_ready(rdy_b),
    .addr1(a1_b), .addr2(a2_b), .wdata1(d1_b), .wdata2(d2_b), .we1(we1_b), .we2(we2_b), .done(done_b)
  );
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic cmp_wr(input string nm, input wr_t got, input wr_t e);
    if (!e.w2) begin
      got.a2 = '0;
      got.d2 = '0;
    end
    check(nm, 64'(got), 64'(e));
  endtask
  // floor division by 256 done with exact arithmetic, then clamp to 16-bit signed
  function automatic logic [15:0] ref_q(input logic signed [31:0] d);
    longint v, t;
    v = d;
    t = (v - ((v % 256 + 256) % 256)) / 256;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t[15:0];
  endfunction
  task automatic mstart(input int u);
    n_m[u] = 0;
    base_m[u] = 0;
    hv_m[u] = 0;
  endtask
  task automatic macc(input int u, input logic [15:0] q);
    wr_t e;
    e = '0;
    n_m[u]++;
    if (hv_m[u] != 0) begin
      e = '{1'b1, 10'(base_m[u]), 10'(base_m[u] + 1), hold_m[u], q};
      base_m[u] += 2;
      hv_m[u] = 0;
    end else if (n_m[u] == tot[u]) begin
      e = '{1'b0, 10'(base_m[u]), 10'd0, q, 16'd0};
    end else begin
      hold_m[u] = q;
      hv_m[u] = 1;
      return;
    end
    if (u == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask
  task automatic pix_a(input logic [31:0] d, input logic [15:0] q);
    vld_a = 1;
    din_a = d;
    @(posedge clk);
    #1 vld_a = 0;
    macc(0, q);
  endtask
  task automatic pix_b(input logic [31:0] d, input logic [15:0] q);
    vld_b = 1;
    din_b = d;
    @(posedge clk);
    #1 vld_b = 0;
    macc(1, q);
  endtask
  task automatic pulse_start_a();
    start_a = 1;
    @(posedge clk);
    #1 start_a = 0;
  endtask
  always @(negedge clk) begin
    if (we1_a) begin
      if (qa.size() == 0) check("wr_a_unexpected", {a1_a, d1_a}, 0);
      else cmp_wr("wr_a", '{we2_a, a1_a, a2_a, d1_a, d2_a}, qa.pop_front());
    end else if (we2_a) check("we2_a_alone", we2_a, 0);
    if (we1_b) begin
      if (qb.size() == 0) check("wr_b_unexpected", {a1_b, d1_b}, 0);
      else cmp_wr("wr_b", '{we2_b, a1_b, a2_b, d1_b, d2_b}, qb.pop_front());
    end else if (we2_b) check("we2_b_alone", we2_b, 0);
  end
  initial begin
    int r;
    mstart(0);
    mstart(1);
    #3;
    check("rst_outs_a", {rdy_a, we1_a, we2_a, done_a, a1_a, a2_a, d1_a, d2_a}, 0);
    check("rst_outs_b", {rdy_b, we1_b, we2_b, done_b}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    vld_a = 1;
    din_a = 32'h100;
    repeat (3) begin
      @(posedge clk);
      #1 check("idle_rdy", rdy_a, 0);
    end
    vld_a = 0;
    pulse_start_a();
    mstart(0);
    check("run_rdy", rdy_a, 1);
    for (int k = 0; k < 9; k++) pix_a(32'(256 * k), 16'(k));
    check("full_rdy", rdy_a, 0);
    check("done_early", done_a, 0);
    @(posedge clk);
    #1 check("done_set", done_a, 1);
    check("addr_kept", {a1_a, d1_a}, {10'd8, 16'd8});
    check("done_rdy", rdy_a, 0);
    vld_a = 1;
    din_a = 32'h500;
    pulse_start_a();
    vld_a = 0;
    mstart(0);
    check("done_drop", done_a, 0);
    pix_a(32'h7FFF_FFFF, 16'h7FFF);
    pix_a(-32'sd256, 16'h0000);
    pix_a(32'h8000_0000, 16'h0000);
    pix_a(32'd255, 16'h0000);
    pix_a(32'd257, 16'h0001);
    pix_a(32'h0080_0000, 16'h7FFF);
    pix_a(32'h007F_FF00, 16'h7FFF);
    pix_a(32'hFFFF_FFFF, 16'h0000);
    pix_a(32'd512, 16'h0002);
    @(posedge clk);
    #1 check("done_a2", done_a, 1);
    start_b = 1;
    @(posedge clk);
    #1 start_b = 0;
    mstart(1);
    pix_b(-32'sd256, 16'hFFFF);
    pix_b(32'h8000_0000, 16'h8000);
    pix_b(32'h7FFF_FFFF, 16'h7FFF);
    pix_b(32'hFF80_0000, 16'h8000);
    pix_b(32'hFF7F_FF00, 16'h8000);
    pix_b(-32'sd255, 16'hFFFF);
    for (int i = 6; i < 576; i++) begin
      while ($urandom_range(1) == 0) begin
        @(posedge clk);
        #1;
      end
      r = int'($urandom_range(0, 33554431)) - 16777216;
      pix_b(32'(r), ref_q(32'(r)));
    end
    check("b_rdy_end", rdy_b, 0);
    @(posedge clk);
    #1 check("done_b", done_b, 1);
    pulse_start_a();
    mstart(0);
    for (int k = 20; k < 25; k++) pix_a(32'(256 * k), 16'(k));
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_a", {rdy_a, we1_a, we2_a, done_a, a1_a, a2_a, d1_a, d2_a}, 0);
    check("async_rst_b", {rdy_b, done_b}, 0);
    check("qa_flushed", qa.size(), 0);
    mstart(0);
    @(posedge clk);
    #1 rst_n = 1;
    pulse_start_a();
    for (int k = 30; k < 33; k++) pix_a(32'(256 * k), 16'(k));
    pulse_start_a();
    check("start_in_run", rdy_a, 1);
    for (int k = 33; k < 39; k++) pix_a(32'(256 * k), 16'(k));
    @(posedge clk);
    #1 check("done_a3", done_a, 1);
    repeat (2) @(posedge clk);
    #1;
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
